scr1_tcm_loader: RTL and testbench

//  Boot-image initiator for the TCM dual-port memory write port (port B).
//  - Accepts a little-endian byte stream (e.g. from a UART receiver) over a valid/ready handshake.
//  - Packs the bytes into SCR1_WIDTH words and writes them from word address 0 upward.
//  - Reads the image back through port B and checks it against a running checksum.
//  - Holds the core in reset until the image has been loaded and verified.

---
 rtl/scr1_tcm_loader.sv | 167 ++++++++++++++++
 tb/tb_scr1_tcm_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_tcm_loader.sv
`timescale 1ns/1ps
// scr1_tcm_loader
// Boot-image initiator for the TCM write port (port B). Packs a little-endian
// byte stream into words, writes them from word 0 upward, reads the image back
// to verify it against a running checksum, and holds the core in reset until
// the image has been loaded and verified.
module scr1_tcm_loader #(
    parameter int SCR1_WIDTH  = 32,
    parameter int SCR1_SIZE   = 65536,
    parameter int SCR1_NBYTES = SCR1_WIDTH / 8,
    parameter int LOAD_BYTES  = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           s_valid,
    input  logic [7:0]                     s_data,
    output logic                           s_ready,
    output logic                           mem_renb,
    output logic                           mem_wenb,
    output logic [SCR1_NBYTES-1:0]         mem_webb,
    output logic [$clog2(SCR1_SIZE)-3:0]   mem_addrb,
    output logic [SCR1_WIDTH-1:0]          mem_datab,
    input  logic [SCR1_WIDTH-1:0]          mem_qb,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    output logic                           core_rst_hold
);

    localparam int AW     = $clog2(SCR1_SIZE) - 2;
    localparam int CW     = $clog2(LOAD_BYTES + 1);
    localparam int LW     = (SCR1_NBYTES > 1) ? $clog2(SCR1_NBYTES) : 1;
    localparam int NWORDS = (LOAD_BYTES + SCR1_NBYTES - 1) / SCR1_NBYTES;
    localparam int TAIL   = LOAD_BYTES % SCR1_NBYTES;

    // Byte mask of the final word: full unless the image ends mid-word.
    localparam logic [SCR1_NBYTES-1:0] LAST_MASK =
        (TAIL == 0) ? {SCR1_NBYTES{1'b1}} : SCR1_NBYTES'((1 << TAIL) - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NWORDS - 1);

    typedef enum logic [2:0] {
        IDLE, RECV, WRITE, VRD, VCMP, CHECK, DONE, ERR
    } state_t;

    state_t                    state, state_next;
    logic [CW-1:0]             byte_cnt;
    logic [LW-1:0]             lane;
    logic [SCR1_WIDTH-1:0]     checksum;
    logic [SCR1_WIDTH-1:0]     vsum;
    logic                      accept;
    logic                      word_full;
    logic                      image_written;
    logic                      last_read;
    logic [SCR1_NBYTES-1:0]    verify_mask;

    // Widen a per-byte enable mask to a per-bit mask.
    function automatic logic [SCR1_WIDTH-1:0] expand_mask(input logic [SCR1_NBYTES-1:0] m);
        logic [SCR1_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < SCR1_NBYTES; i++) begin
            r[8*i +: 8] = {8{m[i]}};
        end
        return r;
    endfunction

    assign accept        = s_valid && s_ready;
    assign word_full     = (lane == LW'(SCR1_NBYTES - 1)) || (byte_cnt == CW'(LOAD_BYTES - 1));
    assign image_written = (byte_cnt == CW'(LOAD_BYTES));
    assign last_read     = (mem_addrb == LAST_ADDR);
    assign verify_mask   = last_read ? LAST_MASK : {SCR1_NBYTES{1'b1}};

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every register
        // samples pre-edge values regardless of block ordering.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic; start is only honoured when no load is in flight.
    always_comb begin
        // NOTE: default first so no path through the case leaves state_next
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RECV;
            RECV:    if (accept && word_full) state_next = WRITE;
            WRITE:   state_next = image_written ? VRD : RECV;
            VRD:     state_next = VCMP;
            VCMP:    state_next = last_read ? CHECK : VRD;
            CHECK:   state_next = (vsum == checksum) ? DONE : ERR;
            DONE:    if (start) state_next = RECV;
            ERR:     if (start) state_next = RECV;
            default: state_next = IDLE;
        endcase
    end

    // Control outputs decoded from the current state.
    always_comb begin
        s_ready       = 1'b0;
        mem_wenb      = 1'b0;
        mem_renb      = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        err           = 1'b0;
        core_rst_hold = 1'b1;
        case (state)
            RECV:    begin s_ready  = 1'b1; busy = 1'b1; end
            WRITE:   begin mem_wenb = 1'b1; busy = 1'b1; end
            VRD:     begin mem_renb = 1'b1; busy = 1'b1; end
            VCMP:    busy = 1'b1;
            CHECK:   busy = 1'b1;
            DONE:    begin done = 1'b1; core_rst_hold = 1'b0; end
            ERR:     err = 1'b1;
            default: ;
        endcase
    end

    // Datapath: byte packing, write addressing, checksum and verify sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt  <= '0;
            lane      <= '0;
            mem_addrb <= '0;
            mem_datab <= '0;
            mem_webb  <= '0;
            checksum  <= '0;
            vsum      <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        byte_cnt  <= '0;
                        lane      <= '0;
                        mem_addrb <= '0;
                        mem_datab <= '0;
                        mem_webb  <= '0;
                        checksum  <= '0;
                        vsum      <= '0;
                    end
                end
                RECV: begin
                    if (accept) begin
                        mem_datab[8*lane +: 8] <= s_data;
                        mem_webb[lane]         <= 1'b1;
                        byte_cnt               <= byte_cnt + 1'b1;
                        lane                   <= lane + 1'b1;
                    end
                end
                WRITE: begin
                    checksum  <= checksum + (mem_datab & expand_mask(mem_webb));
                    mem_datab <= '0;
                    mem_webb  <= '0;
                    lane      <= '0;
                    mem_addrb <= image_written ? '0 : mem_addrb + 1'b1;
                end
                VCMP: begin
                    vsum <= vsum + (mem_qb & expand_mask(verify_mask));
                    if (!last_read) mem_addrb <= mem_addrb + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_scr1_tcm_loader.sv
`timescale 1ns/1ps
// Testbench for scr1_tcm_loader: two instances (8-byte and 6-byte images),
// a port-B memory model with optional read corruption, and a reference model
// that packs the byte image into expected words and byte enables.
module tb_scr1_tcm_loader;

    logic        clk = 1'b0;
    logic        rst, start, s_valid, corrupt, fill_req;
    logic [7:0]  s_data;
    int          sel;

    logic [1:0]  start_i, ready, renb, wenb, busy, done, err, hold;
    logic [3:0]  webb  [2];
    logic [13:0] addr  [2];
    logic [31:0] datab [2];
    logic [31:0] qb    [2];
    logic [31:0] mem   [2][16];

    typedef struct {
        int          addr;
        logic [31:0] data;
        logic [3:0]  webb;
    } wr_t;
    wr_t         wlog[$];
    logic [7:0]  img[$];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign start_i[0] = start && (sel == 0);
    assign start_i[1] = start && (sel == 1);

    scr1_tcm_loader #(.LOAD_BYTES(8)) u8 (
        .clk(clk), .rst(rst), .start(start_i[0]), .s_valid(s_valid), .s_data(s_data),
        .s_ready(ready[0]), .mem_renb(renb[0]), .mem_wenb(wenb[0]), .mem_webb(webb[0]),
        .mem_addrb(addr[0]), .mem_datab(datab[0]), .mem_qb(qb[0]), .busy(busy[0]),
        .done(done[0]), .err(err[0]), .core_rst_hold(hold[0])
    );

    scr1_tcm_loader #(.LOAD_BYTES(6)) u6 (
        .clk(clk), .rst(rst), .start(start_i[1]), .s_valid(s_valid), .s_data(s_data),
        .s_ready(ready[1]), .mem_renb(renb[1]), .mem_wenb(wenb[1]), .mem_webb(webb[1]),
        .mem_addrb(addr[1]), .mem_datab(datab[1]), .mem_qb(qb[1]), .busy(busy[1]),
        .done(done[1]), .err(err[1]), .core_rst_hold(hold[1])
    );

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old_w;
        for (int k = 0; k < 4; k++) if (m[k]) r[8*k +: 8] = new_w[8*k +: 8];
        return r;
    endfunction

    // Port-B memory model: byte-masked writes, registered reads, optional bit-5 flip on word 0.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (fill_req) begin
                for (int w = 0; w < 16; w++) mem[i][w] <= $urandom | 32'h80808080;
            end else if (wenb[i]) begin
                mem[i][addr[i][3:0]] <= merge(mem[i][addr[i][3:0]], datab[i], webb[i]);
                if (i == sel) wlog.push_back('{int'(addr[i]), datab[i], webb[i]});
            end
            if (renb[i])
                qb[i] <= mem[i][addr[i][3:0]] ^
                         ((corrupt && i == sel && addr[i] == 14'd0) ? 32'h20 : 32'h0);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Protocol monitor on the active instance.
    always @(negedge clk) begin
        if (!rst) begin
            check("rw_exclusive", renb[sel] && wenb[sel], 1'b0);
            check("ready_in_write", ready[sel] && wenb[sel], 1'b0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset();
        check("rst_ready", ready[sel], 0);
        check("rst_renb",  renb[sel],  0);
        check("rst_wenb",  wenb[sel],  0);
        check("rst_webb",  webb[sel],  0);
        check("rst_addr",  addr[sel],  0);
        check("rst_datab", datab[sel], 0);
        check("rst_busy",  busy[sel],  0);
        check("rst_done",  done[sel],  0);
        check("rst_err",   err[sel],   0);
        check("rst_hold",  hold[sel],  1);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        s_valid = 1'b1;
        s_data  = b;
        for (n = 0; n < 64; n++) begin
            if (ready[sel]) break;
            tick();
        end
        if (n >= 64) check("send_timeout", 0, 1);
        tick();
        s_valid = 1'b0;
        if (gap != 0) tick();
    endtask

    task automatic rand_img(input int len);
        img.delete();
        for (int i = 0; i < len; i++) img.push_back(8'($urandom));
    endtask

    // One complete load; gap=1 drops s_valid for a cycle after every byte,
    // mid_start >= 0 pulses start after that byte index.
    task automatic run_load(input int gap, input bit exp_ok, input int mid_start);
        int          lb, nw, base, n;
        logic [31:0] ed;
        logic [3:0]  em;
        lb   = (sel == 0) ? 8 : 6;
        nw   = (lb + 3) / 4;
        base = wlog.size();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy",  busy[sel],  1);
        check("start_hold",  hold[sel],  1);
        check("start_ready", ready[sel], 1);
        check("start_done",  done[sel],  0);
        check("start_err",   err[sel],   0);
        for (int i = 0; i < lb; i++) begin
            send_byte(img[i], gap);
            if (i == mid_start) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                check("mid_start_busy",  busy[sel],  1);
                check("mid_start_ready", ready[sel], 1);
            end
        end
        for (n = 0; n < 300; n++) begin
            if (done[sel] || err[sel]) break;
            tick();
        end
        check("end_timeout", n < 300, 1);
        check("n_writes", wlog.size() - base, nw);
        for (int j = 0; j < nw; j++) begin
            ed = '0;
            em = '0;
            for (int k = 0; k < 4; k++) begin
                if (j * 4 + k < lb) begin
                    ed = ed | (32'(img[j*4+k]) << (8 * k));
                    em[k] = 1'b1;
                end
            end
            if (base + j < wlog.size()) begin
                check($sformatf("wr%0d_addr", j), wlog[base+j].addr, j);
                check($sformatf("wr%0d_data", j), wlog[base+j].data, ed);
                check($sformatf("wr%0d_webb", j), wlog[base+j].webb, em);
            end else begin
                check($sformatf("wr%0d_missing", j), 0, 1);
            end
        end
        check("end_done", done[sel], exp_ok);
        check("end_err",  err[sel],  !exp_ok);
        check("end_hold", hold[sel], !exp_ok);
        check("end_busy", busy[sel], 0);
    endtask

    initial begin
        int b;
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
        corrupt = 1'b0; fill_req = 1'b0; sel = 0;
        tick();
        tick();
        sel = 1; check_reset();
        sel = 0; check_reset();
        fill_req = 1'b1;
        tick();
        fill_req = 1'b0;
        rst = 1'b0;
        tick();

        // Known 8-byte image, back-to-back.
        img = '{8'h03, 8'h26, 8'h40, 8'h01, 8'h13, 8'h76, 8'h16, 8'h00};
        b = wlog.size();
        run_load(0, 1'b1, -1);
        if (wlog.size() > b + 1) begin
            check("fixed_w0", wlog[b].data, 32'h01402603);
            check("fixed_w1", wlog[b+1].data, 32'h00167613);
            check("fixed_webb1", wlog[b+1].webb, 4'hF);
        end

        // Same random image back-to-back, then with s_valid toggling (restart from DONE).
        rand_img(8);
        run_load(0, 1'b1, -1);
        run_load(1, 1'b1, -1);

        // Corrupted read-back of word 0 bit 5.
        corrupt = 1'b1;
        rand_img(8);
        run_load(0, 1'b0, -1);
        corrupt = 1'b0;

        // Fresh load started from ERR.
        rand_img(8);
        run_load(1, 1'b1, -1);

        // start pulsed mid-load is ignored.
        rand_img(8);
        run_load(0, 1'b1, 2);

        // Reset during RECV after 6 bytes, then reload from word 0.
        rand_img(8);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) send_byte(img[i], 0);
        rst = 1'b1;
        tick();
        check_reset();
        rst = 1'b0;
        tick();
        rand_img(8);
        run_load(0, 1'b1, -1);

        // 6-byte image: partial last word over garbage bytes.
        sel = 1;
        img = '{8'h03, 8'h26, 8'h40, 8'h01, 8'h13, 8'h76};
        b = wlog.size();
        run_load(0, 1'b1, -1);
        if (wlog.size() > b + 1) begin
            check("partial_webb1", wlog[b+1].webb, 4'h3);
            check("partial_data1", wlog[b+1].data[15:0], 16'h7613);
        end
        rand_img(6);
        run_load(1, 1'b1, -1);
        corrupt = 1'b1;
        rand_img(6);
        run_load(0, 1'b0, -1);
        corrupt = 1'b0;
        rand_img(6);
        run_load(0, 1'b1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
